// File: rtl/uart_rx_os_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_os_pkg
// Shared definitions for the 16x oversampling UART receiver and its tick
// generator. Holds the receive state encoding, the oversample factor, the
// per-bit sample indices used for the 3-sample majority vote and the
// majority helper itself.
// ---------------------------------------------------------------------------
package uart_rx_os_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Oversample factor (samples per bit), fixed.
  localparam int OS = 16;

  // Sample indices inside one bit period.
  localparam logic [3:0] MID_LO  = 4'd7;
  localparam logic [3:0] MID     = 4'd8;
  localparam logic [3:0] MID_HI  = 4'd9;
  localparam logic [3:0] BIT_END = 4'd15;

  // Majority of three samples.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_os_tick.sv
// ---------------------------------------------------------------------------
// uart_os_tick
// Oversample tick generator: a free-running counter 0..DIV-1 with
// DIV = FREQUENCY_IN / (BAUD_RATE * OS). tick_out is a registered one-clock
// pulse emitted each time the counter wraps. Usable by an oversampling
// transmitter as well as by the receiver.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous, active-high reset
//   tick_out out one-clock pulse at OS x baud
// ---------------------------------------------------------------------------
module uart_os_tick
  import uart_rx_os_pkg::*;
#(
  parameter int FREQUENCY_IN = 100_000_000,
  parameter int BAUD_RATE    = 9600
) (
  input  logic clk,
  input  logic rst,
  output logic tick_out
);

  localparam int DIV = FREQUENCY_IN / (BAUD_RATE * OS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Divider counter with explicit wrap and registered tick pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick_out = r_tick;

endmodule

// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
// 8N1 UART receiver, 16x oversampled, 3-sample majority vote per bit
// (samples 7, 8, 9). Delivers each good byte with a one-clock valid pulse,
// flags a low stop bit with a one-clock framing-error pulse and then waits
// in BREAK until the line returns high, so a stuck-low line reports once.
// Ports:
//   clk           in  system clock
//   rst           in  synchronous, active-high reset
//   rx_in         in  asynchronous serial line, idles high
//   rxData_out    out last good byte, held until the next good frame
//   rxValid_out   out one-clock pulse, good byte on rxData_out
//   frameErr_out  out one-clock pulse, stop bit sampled low
//   isBusying_out out high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int FREQUENCY_IN = 100_000_000,
  parameter int BAUD_RATE    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rxData_out,
  output logic       rxValid_out,
  output logic       frameErr_out,
  output logic       isBusying_out
);

  logic        w_tick;
  logic        w_rx;
  logic        w_maj_end;
  logic        w_maj_stop;

  logic        r_sync1;
  logic        r_sync2;
  uart_state_e r_state;
  logic [3:0]  r_s;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  r_samp;
  logic [7:0]  r_sr;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_busy;

  uart_os_tick #(
    .FREQUENCY_IN (FREQUENCY_IN),
    .BAUD_RATE    (BAUD_RATE)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .tick_out (w_tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // At BIT_END the shift register already holds samples 7, 8, 9.
  assign w_maj_end  = maj3(r_samp);
  // The stop bit is decided on sample 9 itself, so fold in the live sample.
  assign w_maj_stop = maj3({r_samp[1:0], w_rx});

  // Receive FSM with registered data, pulse and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_s       <= 4'd0;
      r_bit_cnt <= 3'd0;
      r_samp    <= 3'd0;
      r_sr      <= 8'd0;
      r_data    <= 8'd0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_tick) begin
        if ((r_s == MID_LO) || (r_s == MID) || (r_s == MID_HI)) begin
          r_samp <= {r_samp[1:0], w_rx};
        end
        case (r_state)
          ST_IDLE: begin
            if (!w_rx) begin
              // The edge tick is sample 0, so the next tick is sample 1.
              r_state <= ST_START;
              r_s     <= 4'd1;
              r_busy  <= 1'b1;
            end
          end
          ST_START: begin
            r_s <= r_s + 4'd1;
            if (r_s == BIT_END) begin
              if (!w_maj_end) begin
                r_state   <= ST_DATA;
                r_bit_cnt <= 3'd0;
              end else begin
                // Glitch shorter than half a bit: drop back silently.
                r_state <= ST_IDLE;
                r_s     <= 4'd0;
                r_busy  <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            r_s <= r_s + 4'd1;
            if (r_s == BIT_END) begin
              r_sr      <= {w_maj_end, r_sr[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state <= ST_STOP;
              end
            end
          end
          ST_STOP: begin
            r_s <= r_s + 4'd1;
            // Leaving mid stop bit lets the next start edge be caught even
            // when frames are back to back or the baud is slightly fast.
            if (r_s == MID_HI) begin
              r_s <= 4'd0;
              if (w_maj_stop) begin
                r_data  <= r_sr;
                r_valid <= 1'b1;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            if (w_rx) begin
              r_state <= ST_IDLE;
              r_s     <= 4'd0;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_s     <= 4'd0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rxData_out    = r_data;
  assign rxValid_out   = r_valid;
  assign frameErr_out  = r_ferr;
  assign isBusying_out = r_busy;

endmodule
